// File: rtl/wdt_escalation_ctrl.sv
// wdt_escalation_ctrl
//   Escalates the watchdog timeout flag. The first rising edge of timeout_in
//   raises a warning interrupt and opens a grace window. If software does not
//   service within the window, the block pulses a system reset, force-services
//   the watchdog and records the cause. Once MAX_RESETS watchdog resets have
//   been counted, the system is held in reset until rst.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         asynchronous active-high reset
//   timeout_in  level timeout flag from the watchdog counter
//   service_in  software kick (also drives the watchdog service input)
//   irq_ack     software acknowledge, clears irq
//   clr_cause   clears wdt_cause and reset_cnt (IDLE/WARN only)
//   irq         warning interrupt (level)
//   sys_rst     system reset request
//   wdt_reload  forced service to the watchdog
//   lockout     permanent lockout indication
//   wdt_cause   sticky: last system reset came from the watchdog
//   reset_cnt   saturating count of watchdog resets
//   state       FSM state
//
// state  | meaning
// IDLE   | waiting for a timeout rising edge
// WARN   | irq raised, grace window counting down
// RESET  | sys_rst/wdt_reload pulse in progress
// LOCK   | terminal, system held in reset

module wdt_escalation_ctrl #(
    parameter int GRACE_CYCLES = 16,
    parameter int RST_LEN      = 4,
    parameter int MAX_RESETS   = 3,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timeout_in,
    input  logic             service_in,
    input  logic             irq_ack,
    input  logic             clr_cause,
    output logic             irq,
    output logic             sys_rst,
    output logic             wdt_reload,
    output logic             lockout,
    output logic             wdt_cause,
    output logic [CNT_W-1:0] reset_cnt,
    output logic [1:0]       state
);

    localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
    localparam int RW = $clog2(RST_LEN);

    localparam logic [GW-1:0]    GRACE_LOAD = GW'(GRACE_CYCLES - 1);
    localparam logic [RW-1:0]    RST_LOAD   = RW'(RST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(MAX_RESETS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARN  = 2'd1,
        ST_RESET = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             timeout_q, timeout_d;
    logic [GW-1:0]    grace_q, grace_d;
    logic [RW-1:0]    rst_len_q, rst_len_d;
    logic             irq_q, irq_d;
    logic             sys_rst_q, sys_rst_d;
    logic             wdt_reload_q, wdt_reload_d;
    logic             lockout_q, lockout_d;
    logic             wdt_cause_q, wdt_cause_d;
    logic [CNT_W-1:0] reset_cnt_q, reset_cnt_d;
    logic             trigger;

    // A level held from before the edge must never re-arm the warning.
    assign trigger = timeout_in & ~timeout_q;

    always_comb begin
        state_d      = state_q;
        timeout_d    = timeout_in;
        grace_d      = grace_q;
        rst_len_d    = rst_len_q;
        irq_d        = irq_q;
        sys_rst_d    = sys_rst_q;
        wdt_reload_d = wdt_reload_q;
        lockout_d    = lockout_q;
        wdt_cause_d  = wdt_cause_q;
        reset_cnt_d  = reset_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_cause) begin
                    wdt_cause_d = 1'b0;
                    reset_cnt_d = '0;
                end
                if (trigger && !service_in) begin
                    state_d = ST_WARN;
                    irq_d   = 1'b1;
                    grace_d = GRACE_LOAD;
                end
            end

            ST_WARN: begin
                if (clr_cause) begin
                    wdt_cause_d = 1'b0;
                    reset_cnt_d = '0;
                end
                if (irq_ack) begin
                    irq_d = 1'b0;
                end
                if (service_in) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end else if (grace_q == '0) begin
                    // Escalation overrides a same-cycle clr_cause; count from the held value.
                    state_d      = ST_RESET;
                    irq_d        = 1'b0;
                    sys_rst_d    = 1'b1;
                    wdt_reload_d = 1'b1;
                    wdt_cause_d  = 1'b1;
                    reset_cnt_d  = (reset_cnt_q == CNT_SAT) ? reset_cnt_q
                                                             : reset_cnt_q + 1'b1;
                    rst_len_d    = RST_LOAD;
                end else begin
                    grace_d = grace_q - 1'b1;
                end
            end

            ST_RESET: begin
                if (rst_len_q == '0) begin
                    wdt_reload_d = 1'b0;
                    if (reset_cnt_q >= CNT_LIMIT) begin
                        state_d   = ST_LOCK;
                        lockout_d = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        sys_rst_d = 1'b0;
                    end
                end else begin
                    rst_len_d = rst_len_q - 1'b1;
                end
            end

            ST_LOCK: begin
                sys_rst_d    = 1'b1;
                lockout_d    = 1'b1;
                wdt_reload_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timeout_q    <= 1'b0;
            grace_q      <= '0;
            rst_len_q    <= '0;
            irq_q        <= 1'b0;
            sys_rst_q    <= 1'b0;
            wdt_reload_q <= 1'b0;
            lockout_q    <= 1'b0;
            wdt_cause_q  <= 1'b0;
            reset_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            timeout_q    <= timeout_d;
            grace_q      <= grace_d;
            rst_len_q    <= rst_len_d;
            irq_q        <= irq_d;
            sys_rst_q    <= sys_rst_d;
            wdt_reload_q <= wdt_reload_d;
            lockout_q    <= lockout_d;
            wdt_cause_q  <= wdt_cause_d;
            reset_cnt_q  <= reset_cnt_d;
        end
    end

    assign irq        = irq_q;
    assign sys_rst    = sys_rst_q;
    assign wdt_reload = wdt_reload_q;
    assign lockout    = lockout_q;
    assign wdt_cause  = wdt_cause_q;
    assign reset_cnt  = reset_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_wdt_escalation_ctrl.sv
// Testbench for wdt_escalation_ctrl: directed escalation scenarios followed by
// a randomized run, all compared against a cycle-level behavioural model.

module tb_wdt_escalation_ctrl;

    localparam int GRACE = 8;
    localparam int RLEN  = 4;
    localparam int MAXR  = 2;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          timeout_in, service_in, irq_ack, clr_cause;
    logic          irq, sys_rst, wdt_reload, lockout, wdt_cause;
    logic [CW-1:0] reset_cnt;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;

    // behavioural model: mode 0 idle, 1 warning, 2 reset pulse, 3 locked
    int m_mode, m_warn_el, m_rst_el, m_cnt;
    bit m_prev_to, m_irq, m_sys, m_rel, m_lock, m_cause;

    int n_irq, n_sys, n_rel;

    wdt_escalation_ctrl #(
        .GRACE_CYCLES(GRACE), .RST_LEN(RLEN), .MAX_RESETS(MAXR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .timeout_in(timeout_in), .service_in(service_in),
        .irq_ack(irq_ack), .clr_cause(clr_cause), .irq(irq), .sys_rst(sys_rst),
        .wdt_reload(wdt_reload), .lockout(lockout), .wdt_cause(wdt_cause),
        .reset_cnt(reset_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_warn_el = 0; m_rst_el = 0; m_cnt = 0;
        m_prev_to = 0; m_irq = 0; m_sys = 0; m_rel = 0; m_lock = 0; m_cause = 0;
    endtask

    task automatic model_step(input bit to, input bit svc, input bit ack, input bit clr);
        bit trig;
        int old_cnt;
        trig    = to && !m_prev_to;
        old_cnt = m_cnt;
        case (m_mode)
            0: begin
                if (clr) begin m_cause = 0; m_cnt = 0; end
                if (trig && !svc) begin m_mode = 1; m_irq = 1; m_warn_el = 1; end
            end
            1: begin
                if (clr) begin m_cause = 0; m_cnt = 0; end
                if (ack) m_irq = 0;
                if (svc) begin
                    m_mode = 0; m_irq = 0;
                end else if (m_warn_el == GRACE) begin
                    m_mode = 2; m_irq = 0; m_sys = 1; m_rel = 1; m_cause = 1;
                    m_cnt = (old_cnt >= SAT) ? SAT : old_cnt + 1;
                    m_rst_el = 1;
                end else begin
                    m_warn_el++;
                end
            end
            2: begin
                if (m_rst_el == RLEN) begin
                    m_rel = 0;
                    if (m_cnt >= MAXR) begin m_mode = 3; m_lock = 1; end
                    else begin m_mode = 0; m_sys = 0; end
                end else begin
                    m_rst_el++;
                end
            end
            default: ;
        endcase
        m_prev_to = to;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},   32'(state),      32'(m_mode));
        chk({tag, ".irq"},     32'(irq),        32'(m_irq));
        chk({tag, ".sys_rst"}, 32'(sys_rst),    32'(m_sys));
        chk({tag, ".reload"},  32'(wdt_reload), 32'(m_rel));
        chk({tag, ".lockout"}, 32'(lockout),    32'(m_lock));
        chk({tag, ".cause"},   32'(wdt_cause),  32'(m_cause));
        chk({tag, ".cnt"},     32'(reset_cnt),  32'(m_cnt));
    endtask

    task automatic tick(input string tag);
        model_step(timeout_in, service_in, irq_ack, clr_cause);
        @(posedge clk);
        #1;
        check_all(tag);
        if (irq)        n_irq++;
        if (sys_rst)    n_sys++;
        if (wdt_reload) n_rel++;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #2;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        n_irq = 0; n_sys = 0; n_rel = 0;
    endtask

    initial begin
        rst = 1'b1;
        timeout_in = 1'b0; service_in = 1'b0; irq_ack = 1'b0; clr_cause = 1'b0;
        model_reset();
        clear_counts();
        #12;
        chk("por.state", 32'(state), 32'd0);
        chk("por.outs", 32'({irq, sys_rst, wdt_reload, lockout, wdt_cause}), 32'd0);
        chk("por.cnt", 32'(reset_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: service three cycles after irq
        clear_counts();
        timeout_in = 1'b1;
        tick("s1");
        chk("s1.irq_rise", 32'(irq), 32'd1);
        tick("s1");
        tick("s1");
        service_in = 1'b1;
        tick("s1");
        service_in = 1'b0; timeout_in = 1'b0;
        tick("s1");
        chk("s1.irq_cycles", 32'(n_irq), 32'd3);
        chk("s1.no_sysrst", 32'(n_sys), 32'd0);
        chk("s1.state", 32'(state), 32'd0);
        chk("s1.cause", 32'(wdt_cause), 32'd0);

        // 2: first escalation
        clear_counts();
        timeout_in = 1'b1;
        tick("s2");
        timeout_in = 1'b0;
        repeat (19) tick("s2");
        chk("s2.irq_cycles", 32'(n_irq), 32'd8);
        chk("s2.sys_cycles", 32'(n_sys), 32'd4);
        chk("s2.rel_cycles", 32'(n_rel), 32'd4);
        chk("s2.cause", 32'(wdt_cause), 32'd1);
        chk("s2.cnt", 32'(reset_cnt), 32'd1);
        chk("s2.state", 32'(state), 32'd0);

        // 3: second escalation locks
        clear_counts();
        timeout_in = 1'b1;
        tick("s3");
        timeout_in = 1'b0;
        repeat (19) tick("s3");
        chk("s3.irq_cycles", 32'(n_irq), 32'd8);
        chk("s3.rel_cycles", 32'(n_rel), 32'd4);
        chk("s3.state", 32'(state), 32'd3);
        chk("s3.lockout", 32'(lockout), 32'd1);
        chk("s3.sys_rst", 32'(sys_rst), 32'd1);
        chk("s3.cnt", 32'(reset_cnt), 32'd2);
        service_in = 1'b1; irq_ack = 1'b1; clr_cause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            timeout_in = i[0];
            tick("s3lk");
        end
        service_in = 1'b0; irq_ack = 1'b0; clr_cause = 1'b0; timeout_in = 1'b0;
        chk("s3.lock_state", 32'(state), 32'd3);
        chk("s3.lock_sys", 32'(sys_rst), 32'd1);
        chk("s3.lock_reload", 32'(wdt_reload), 32'd0);
        chk("s3.lock_cause", 32'(wdt_cause), 32'd1);
        do_reset("s3rst");
        chk("s3.after_rst", 32'({state, lockout, sys_rst}), 32'd0);

        // 4: same-cycle service beats trigger; service on final WARN cycle
        clear_counts();
        timeout_in = 1'b1; service_in = 1'b1;
        tick("s4");
        service_in = 1'b0;
        tick("s4");
        chk("s4.no_irq", 32'(n_irq), 32'd0);
        timeout_in = 1'b0;
        tick("s4");
        timeout_in = 1'b1;
        tick("s4");
        chk("s4.warn", 32'(state), 32'd1);
        timeout_in = 1'b0;
        repeat (7) tick("s4");
        chk("s4.still_warn", 32'(state), 32'd1);
        service_in = 1'b1;
        tick("s4");
        service_in = 1'b0;
        tick("s4");
        chk("s4.idle", 32'(state), 32'd0);
        chk("s4.no_sysrst", 32'(n_sys), 32'd0);

        // 5: held timeout, irq_ack mid-window, clr_cause after reset
        clear_counts();
        timeout_in = 1'b1;
        tick("s5");
        irq_ack = 1'b1;
        tick("s5");
        irq_ack = 1'b0;
        chk("s5.ack_irq", 32'(irq), 32'd0);
        chk("s5.ack_state", 32'(state), 32'd1);
        repeat (6) tick("s5");
        chk("s5.pre_rst", 32'(sys_rst), 32'd0);
        tick("s5");
        chk("s5.rst_on_time", 32'(sys_rst), 32'd1);
        repeat (4) tick("s5");
        chk("s5.back_idle", 32'(state), 32'd0);
        repeat (3) tick("s5");
        chk("s5.no_retrig", 32'({state, irq}), 32'd0);
        chk("s5.cause_set", 32'(wdt_cause), 32'd1);
        clr_cause = 1'b1;
        tick("s5");
        clr_cause = 1'b0;
        chk("s5.clr_cause", 32'(wdt_cause), 32'd0);
        chk("s5.clr_cnt", 32'(reset_cnt), 32'd0);

        // 6: async reset in 2nd RESET cycle
        timeout_in = 1'b0;
        tick("s6");
        timeout_in = 1'b1;
        tick("s6");
        timeout_in = 1'b0;
        repeat (8) tick("s6");
        chk("s6.in_reset", 32'(state), 32'd2);
        tick("s6");
        chk("s6.pulse", 32'(sys_rst), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("s6.async_outs", 32'({irq, sys_rst, wdt_reload, lockout, wdt_cause}), 32'd0);
        chk("s6.async_state", 32'(state), 32'd0);
        chk("s6.async_cnt", 32'(reset_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) timeout_in = ~timeout_in;
            service_in = ($urandom_range(19) == 0);
            irq_ack    = ($urandom_range(7) == 0);
            clr_cause  = ($urandom_range(14) == 0);
            if ($urandom_range(399) == 0 || (m_mode == 3 && $urandom_range(19) == 0))
                do_reset("rnd_rst");
            else
                tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
